// File: rtl/weight_feed_ctrl_if.sv
// Bundle of job-config, weight-buffer and weight-mux signals for weight_feed_ctrl.
// The slave modport is the sequencer; the master side is the job issuer/buffer/array.
interface weight_feed_ctrl_if #(
    parameter int unsigned ADDR_W = 8
) ();
    logic              start;
    logic [2:0]        cfg_bitwidth;
    logic [ADDR_W-1:0] cfg_base_addr;
    logic [ADDR_W:0]   cfg_num_words;
    logic              busy;
    logic              done;
    logic              cfg_err;
    logic              buf_rd_en;
    logic [ADDR_W-1:0] buf_addr;
    logic [31:0]       buf_rdata;
    logic [2:0]        mux_bitwidth;
    logic              mux_rd_en;
    logic [31:0]       mux_data_in;
    logic              array_ready;
    logic              out_valid;
    logic [ADDR_W:0]   zero_words;

    modport slave (
        input  start, cfg_bitwidth, cfg_base_addr, cfg_num_words, buf_rdata, array_ready,
        output busy, done, cfg_err, buf_rd_en, buf_addr, mux_bitwidth, mux_rd_en,
               mux_data_in, out_valid, zero_words
    );

    modport master (
        output start, cfg_bitwidth, cfg_base_addr, cfg_num_words, buf_rdata, array_ready,
        input  busy, done, cfg_err, buf_rd_en, buf_addr, mux_bitwidth, mux_rd_en,
               mux_data_in, out_valid, zero_words
    );
endinterface

// File: rtl/weight_feed_ctrl.sv
// Weight-feed sequencer: fetches packed weight words and strobes the systolic-array mux
// for 4/2/1 beats per word (8/4/2-bit weights), honouring array back-pressure.
module weight_feed_ctrl #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    weight_feed_ctrl_if.slave bus_io
);

    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StFeed, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        bw_q, bw_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   num_q, num_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        beat_q, beat_d;
    logic [ADDR_W:0]   zero_q, zero_d;
    logic              cfg_err_q, cfg_err_d;
    logic              out_valid_q;

    logic              cfg_legal;
    logic              last_beat;
    logic              buf_rd_en;
    logic              mux_rd_en;
    logic [ADDR_W:0]   idx_inc;

    assign cfg_legal = (bus_io.cfg_bitwidth == 3'b001) || (bus_io.cfg_bitwidth == 3'b010) ||
                       (bus_io.cfg_bitwidth == 3'b100);
    assign idx_inc   = idx_q + 1'b1;

    always_comb begin
        last_beat = 1'b1;
        unique case (bw_q)
            3'b100:  last_beat = (beat_q == 2'd3);
            3'b010:  last_beat = (beat_q == 2'd1);
            default: last_beat = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bw_d      = bw_q;
        base_d    = base_q;
        num_d     = num_q;
        idx_d     = idx_q;
        word_d    = word_q;
        beat_d    = beat_q;
        zero_d    = zero_q;
        cfg_err_d = 1'b0;
        buf_rd_en = 1'b0;
        mux_rd_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    if (!cfg_legal) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        bw_d    = bus_io.cfg_bitwidth;
                        base_d  = bus_io.cfg_base_addr;
                        num_d   = bus_io.cfg_num_words;
                        idx_d   = '0;
                        zero_d  = '0;
                        state_d = (bus_io.cfg_num_words == '0) ? StDone : StFetch;
                    end
                end
            end
            StFetch: begin
                buf_rd_en = 1'b1;
                state_d   = StLoad;
            end
            StLoad: begin
                word_d  = bus_io.buf_rdata;
                if (bus_io.buf_rdata == 32'd0) begin
                    zero_d = zero_q + 1'b1;
                end
                beat_d  = '0;
                state_d = StFeed;
            end
            StFeed: begin
                // Beats only advance when the array takes them, keeping the mux pointer aligned.
                mux_rd_en = bus_io.array_ready;
                if (bus_io.array_ready) begin
                    if (last_beat) begin
                        idx_d   = idx_inc;
                        state_d = (idx_inc == num_q) ? StDone : StFetch;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            bw_q        <= 3'b100;
            base_q      <= '0;
            num_q       <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            beat_q      <= '0;
            zero_q      <= '0;
            cfg_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bw_q        <= bw_d;
            base_q      <= base_d;
            num_q       <= num_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            beat_q      <= beat_d;
            zero_q      <= zero_d;
            cfg_err_q   <= cfg_err_d;
            out_valid_q <= mux_rd_en;
        end
    end

    assign bus_io.busy         = (state_q != StIdle);
    assign bus_io.done         = (state_q == StDone);
    assign bus_io.cfg_err      = cfg_err_q;
    assign bus_io.buf_rd_en    = buf_rd_en;
    assign bus_io.buf_addr     = base_q + idx_q[ADDR_W-1:0];
    assign bus_io.mux_bitwidth = bw_q;
    assign bus_io.mux_rd_en    = mux_rd_en;
    assign bus_io.mux_data_in  = word_q;
    assign bus_io.out_valid    = out_valid_q;
    assign bus_io.zero_words   = zero_q;

endmodule
